sram_port0_arbiter: RTL and testbench
=====================================

# sram_port0_arbiter

Two-requester arbiter and sequencer for the RW port (port 0) of the 1 KB, 32-bit OpenRAM macro on the test chip. It accepts independent read/write requests from requesters A and B with valid/ready handshakes and grants them round-robin, at most one per cycle. It drives the macro's registered port-0 inputs and captures `dout0` at the correct edge. Each read result is returned to the requester that issued it. Port 1 (read-only) is outside this block.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width; must match the macro.
- `ADDR_WIDTH`, 8, word address width (256 words).
- `NUM_WMASK`, 4, byte write-enable count, equal to `DATA_WIDTH/8`.

Ports:
- `clk0`  in  1  the one clock, shared with macro port 0.
- `rst0`  in  1  reset, synchronous and active-high.
- `a_valid`, `b_valid`  in  1  request present.
- `a_ready`, `b_ready`  out  1  request granted this cycle (combinational).
- `a_we`, `b_we`  in  1  1 = write, 0 = read.
- `a_addr`, `b_addr`  in  ADDR_WIDTH  word address.
- `a_wdata`, `b_wdata`  in  DATA_WIDTH  write data.
- `a_wmask`, `b_wmask`  in  NUM_WMASK  byte enables; ignored for reads.
- `a_rvalid`, `b_rvalid`  out  1  one-cycle pulse, read data valid.
- `a_rdata`, `b_rdata`  out  DATA_WIDTH  read data, held until the next pulse for that requester.
- `csb0`, `web0`  out  1  macro chip-select-bar and write-enable-bar (active-low).
- `wmask0`  out  NUM_WMASK  macro byte mask.
- `addr0`  out  ADDR_WIDTH  macro address.
- `din0`  out  DATA_WIDTH  macro write data.
- `dout0`  in  DATA_WIDTH  macro read data.

## Operation
- **Handshake:** a transfer occurs when `x_valid && x_ready` at a rising edge of `clk0`.
  - `x_ready` is never high while `x_valid` is low.
  - A requester holds its request fields stable while `x_valid` is high and `x_ready` is low.
- **Arbitration:** one grant per cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, the one named by `rr_ptr` is granted.
  - After a contested grant, `rr_ptr` points to the loser.
  - After an uncontested grant, `rr_ptr` points to the requester that was not granted.
  - `rr_ptr` is unchanged in idle cycles.
- **Issue stage:** on a grant at edge k, macro outputs are registered at edge k:
  - `csb0=0`, `web0=!we`, `addr0`, `din0`;
  - `wmask0` = request mask for writes, 0 for reads.
- **Idle issue:** with no grant at edge k, the registers update to `csb0=1`, `web0=1`, `wmask0=0`; `addr0` and `din0` hold.
- **Tag pipeline:** a 2-stage pipeline carries {is_read, requester id} alongside each issue.
- **Read return:** at edge k+2, `dout0` is captured into `x_rdata` for the tagged requester, and `x_rvalid` is high for the cycle following edge k+2.
- **Writes** produce no response.
- **Back-to-back ordering:** a read of an address accepted in the cycle after a write to the same address returns the new data. The macro writes at the negedge before it samples the following read, so no forwarding logic is needed.
- **No backpressure:** there is none on read return. Sustained throughput is one request per cycle.
- **Per-requester ordering:** responses to each requester return in request order.

## Timing
- **Reset values** (at the edge where `rst0` is sampled high):
  - `csb0=1`, `web0=1`, `wmask0=0`, `addr0=0`, `din0=0`;
  - `a_rvalid=b_rvalid=0`, `a_rdata=b_rdata=0`;
  - `rr_ptr=A`, tag pipeline cleared.
- **During reset:** `a_ready` and `b_ready` are 0.
- **Reset mid-operation:**
  - In-flight reads are dropped; no `rvalid` is produced for them.
  - A write already captured by the macro still completes, because the macro itself is not reset.
- **Latencies:**
  - Read: accept edge k to `rvalid` edge k+2 (2 cycles).
  - Write: committed to the array at the negedge after edge k+1.
- **Sampling window:** `dout0` is sampled only at edge k+2. It is valid from negedge k+1 plus the macro delay until T_HOLD after edge k+2.
- **Simultaneous events:**
  - Both requesters valid: exactly one `ready`.
  - An `rvalid` pulse and a new grant to the same requester in the same cycle are allowed.

## Structure
- **Shared package `sram_ctrl_pkg`:**
  - `SRAM_DATA_WIDTH`, `SRAM_ADDR_WIDTH`, `SRAM_NUM_WMASK` constants;
  - `req_id_t` enum {REQ_A, REQ_B};
  - a tag struct {is_read, id}.
- **Sub-module `sram_rr_arbiter2`:** combinational 2-way grant plus the registered `rr_ptr`.
- **Top level:** issue registers, tag pipeline and return demux.

## Test plan
- **Reset:** assert `rst0` for 2 cycles -> `csb0=1`, `web0=1`, `wmask0=0`, all `rvalid=0`, all `ready=0`.
- **A write then read:** A writes 0xDEADBEEF to 0x10 with mask 4'hF, then reads 0x10 on the next cycle -> `a_rvalid` exactly 2 cycles after the read acceptance, `a_rdata=0xDEADBEEF`.
- **Partial write:** write 0x11223344 with mask 4'b0101 over 0xFFFFFFFF at 0x20, then read -> 0xFF22FF44.
- **Contention:** A and B continuously valid for 6 cycles -> grants alternate A,B,A,B,A,B. Reads return to their own requester in order; no `rvalid` on the wrong side.
- **Reset mid-read:** B read accepted at edge k, `rst0` high at edge k+1 -> no `b_rvalid`; first post-reset grant goes to A.
- **Streaming:** A reads 0x00–0x07 one per cycle -> eight consecutive `a_rvalid` pulses with the matching data, `csb0` low throughout.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM port controllers.
// Tags follow each macro issue so read data can be routed back.
package sram_ctrl_pkg;

  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_ADDR_WIDTH = 8;
  localparam int SRAM_NUM_WMASK  = SRAM_DATA_WIDTH / 8;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    is_read;
    req_id_t id;
  } sram_tag_t;

  localparam sram_tag_t TAG_IDLE = '{
    is_read: 1'b0,
    id:      REQ_A
  };

  function automatic logic tag_hit(
    input sram_tag_t t,
    input req_id_t   id
  );
    return t.is_read && (t.id == id);
  endfunction

endpackage

// File: rtl/sram_rr_arbiter2.sv
// Two-way round-robin grant; the pointer always names the
// requester that was not served by the most recent grant.
module sram_rr_arbiter2
  import sram_ctrl_pkg::*;
(
  input  logic clk0,
  input  logic rst0,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_gnt,
  output logic b_gnt
);

  req_id_t rr_ptr;

  // No grants while reset is held.
  assign a_gnt = !rst0 && a_valid
               && (!b_valid || rr_ptr == REQ_A);
  assign b_gnt = !rst0 && b_valid
               && (!a_valid || rr_ptr == REQ_B);

  always_ff @(posedge clk0) begin
    if (rst0) begin
      rr_ptr <= REQ_A;
    end else if (a_gnt) begin
      rr_ptr <= REQ_B;
    end else if (b_gnt) begin
      rr_ptr <= REQ_A;
    end
  end

endmodule

// File: rtl/sram_port0_arbiter.sv
// Port-0 sequencer for the OpenRAM macro: arbitrates A/B,
// registers macro inputs and routes read data back by tag.
module sram_port0_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int NUM_WMASK  = SRAM_NUM_WMASK
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [NUM_WMASK-1:0]  a_wmask,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic [NUM_WMASK-1:0]  b_wmask,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASK-1:0]  wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  logic      a_gnt;
  logic      b_gnt;
  sram_tag_t tag_q1;
  sram_tag_t tag_q2;

  sram_rr_arbiter2 u_arb (
    .clk0    (clk0),
    .rst0    (rst0),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_gnt   (a_gnt),
    .b_gnt   (b_gnt)
  );

  assign a_ready = a_gnt;
  assign b_ready = b_gnt;

  // addr0/din0 hold when idle to avoid needless macro toggling.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      csb0   <= 1'b1;
      web0   <= 1'b1;
      wmask0 <= '0;
      addr0  <= '0;
      din0   <= '0;
      tag_q1 <= TAG_IDLE;
      tag_q2 <= TAG_IDLE;
    end else begin
      tag_q2 <= tag_q1;
      unique case (1'b1)
        a_gnt: begin
          csb0   <= 1'b0;
          web0   <= !a_we;
          wmask0 <= a_we ? a_wmask : '0;
          addr0  <= a_addr;
          din0   <= a_wdata;
          tag_q1 <= '{is_read: !a_we, id: REQ_A};
        end
        b_gnt: begin
          csb0   <= 1'b0;
          web0   <= !b_we;
          wmask0 <= b_we ? b_wmask : '0;
          addr0  <= b_addr;
          din0   <= b_wdata;
          tag_q1 <= '{is_read: !b_we, id: REQ_B};
        end
        default: begin
          csb0   <= 1'b1;
          web0   <= 1'b1;
          wmask0 <= '0;
          tag_q1 <= TAG_IDLE;
        end
      endcase
    end
  end

  // dout0 is only stable around the edge two after issue.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= tag_hit(tag_q2, REQ_A);
      b_rvalid <= tag_hit(tag_q2, REQ_B);
      if (tag_hit(tag_q2, REQ_A)) a_rdata <= dout0;
      if (tag_hit(tag_q2, REQ_B)) b_rdata <= dout0;
    end
  end

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Bench for sram_port0_arbiter: behavioural macro model plus a
// transaction-level reference (memory array + response queues).
module tb_sram_port0_arbiter;

  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic        rst0 = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic        a_we = 1'b0, b_we = 1'b0;
  logic [7:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic [3:0]  a_wmask = '0, b_wmask = '0;
  logic        a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        csb0, web0;
  logic [3:0]  wmask0;
  logic [7:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0 = '0;

  sram_port0_arbiter dut (
    .clk0(clk0), .rst0(rst0),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_wmask(a_wmask),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_wmask(b_wmask),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  // OpenRAM-like macro: inputs latched at posedge, array op at negedge.
  logic [31:0] mem [256];
  logic        mc_csb, mc_web;
  logic [3:0]  mc_wm;
  logic [7:0]  mc_ad;
  logic [31:0] mc_din;
  bit          minit = 1'b0;

  always @(posedge clk0) begin
    mc_csb <= csb0; mc_web <= web0; mc_wm <= wmask0;
    mc_ad <= addr0; mc_din <= din0;
  end

  always @(negedge clk0) begin
    if (!minit) begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      minit = 1'b1;
    end else if (mc_csb === 1'b0) begin
      if (mc_web) dout0 <= mem[mc_ad];
      else
        for (int j = 0; j < 4; j++)
          if (mc_wm[j]) mem[mc_ad][8*j +: 8] = mc_din[8*j +: 8];
    end
  end

  // Reference model state
  typedef struct { int due; logic [31:0] data; } resp_t;
  logic [31:0] rmem [256];
  resp_t       qa[$], qb[$];
  int          m_rr = 0;
  logic [31:0] last_a = '0, last_b = '0;
  logic        e_csb = 1'b1, e_web = 1'b1;
  logic [3:0]  e_wm = '0;
  logic [7:0]  e_addr = '0;
  logic [31:0] e_din = '0;
  bit          g_a = 1'b0, g_b = 1'b0;
  int          cyc = 0, npass = 0, ntot = 0;

  typedef struct {
    bit av, bv, awe, bwe;
    logic [7:0] aad, bad;
    bit ear, ebr;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h at cycle %0d",
                  nm, act, exp, cyc);
  endtask

  task automatic serve(input bit is_b);
    logic we; logic [7:0] ad; logic [31:0] wd; logic [3:0] wm;
    resp_t r;
    we = is_b ? b_we : a_we;
    ad = is_b ? b_addr : a_addr;
    wd = is_b ? b_wdata : a_wdata;
    wm = is_b ? b_wmask : a_wmask;
    e_csb = 1'b0; e_web = !we; e_wm = we ? wm : 4'h0;
    e_addr = ad; e_din = wd;
    if (we) begin
      for (int j = 0; j < 4; j++)
        if (wm[j]) rmem[ad][8*j +: 8] = wd[8*j +: 8];
    end else begin
      r.due = cyc + 3;
      r.data = rmem[ad];
      if (is_b) qb.push_back(r); else qa.push_back(r);
    end
  endtask

  task automatic check_outputs();
    bit ea, eb;
    ea = (qa.size() > 0) && (qa[0].due == cyc);
    eb = (qb.size() > 0) && (qb[0].due == cyc);
    chk("csb0", csb0, e_csb);
    chk("web0", web0, e_web);
    chk("wmask0", wmask0, e_wm);
    chk("addr0", addr0, e_addr);
    chk("din0", din0, e_din);
    chk("a_rvalid", a_rvalid, ea);
    chk("b_rvalid", b_rvalid, eb);
    if (ea) begin last_a = qa[0].data; void'(qa.pop_front()); end
    if (eb) begin last_b = qb[0].data; void'(qb.pop_front()); end
    chk("a_rdata", a_rdata, last_a);
    chk("b_rdata", b_rdata, last_b);
  endtask

  // Called at a negedge with inputs already driven.
  task automatic tick(input bit use_tbl, input bit ear, input bit ebr);
    bit ga, gb;
    #1;
    ga = !rst0 && a_valid && (!b_valid || m_rr == 0);
    gb = !rst0 && b_valid && (!a_valid || m_rr == 1);
    if (use_tbl) begin
      chk("tbl_a_ready", a_ready, ear);
      chk("tbl_b_ready", b_ready, ebr);
    end else begin
      chk("a_ready", a_ready, ga);
      chk("b_ready", b_ready, gb);
    end
    if (rst0) begin
      m_rr = 0; qa.delete(); qb.delete();
      e_csb = 1; e_web = 1; e_wm = 0; e_addr = 0; e_din = 0;
      last_a = 0; last_b = 0;
    end else if (ga) begin
      serve(1'b0); m_rr = 1;
    end else if (gb) begin
      serve(1'b1); m_rr = 0;
    end else begin
      e_csb = 1; e_web = 1; e_wm = 0;
    end
    g_a = ga; g_b = gb;
    @(posedge clk0);
    cyc++;
    @(negedge clk0);
    check_outputs();
  endtask

  task automatic idle(input int n);
    a_valid = 0; b_valid = 0;
    repeat (n) tick(0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rmem[i] = init_word(i);
    tbl[0]  = '{1, 1, 0, 0, 8'h10, 8'h20, 1, 0};
    tbl[1]  = '{1, 1, 0, 0, 8'h10, 8'h20, 0, 1};
    tbl[2]  = '{1, 1, 0, 0, 8'h10, 8'h20, 1, 0};
    tbl[3]  = '{1, 1, 0, 0, 8'h10, 8'h20, 0, 1};
    tbl[4]  = '{1, 1, 0, 0, 8'h10, 8'h20, 1, 0};
    tbl[5]  = '{1, 1, 0, 0, 8'h10, 8'h20, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 8'h10, 8'h20, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 8'h10, 8'h21, 0, 1};
    tbl[8]  = '{1, 0, 0, 0, 8'h11, 8'h21, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 8'h11, 8'h21, 0, 0};
    tbl[10] = '{1, 1, 0, 0, 8'h12, 8'h22, 0, 1};
    tbl[11] = '{0, 1, 0, 1, 8'h12, 8'h40, 0, 1};
    tbl[12] = '{1, 1, 0, 0, 8'h12, 8'h40, 1, 0};

    rst0 = 1;
    repeat (2) @(negedge clk0);
    // Reset held 2 cycles with both requesters asking
    a_valid = 1; b_valid = 1;
    tick(0, 0, 0);
    tick(0, 0, 0);
    a_valid = 0; b_valid = 0;
    rst0 = 0;

    // Arbitration table: starts with pointer at A
    b_wdata = 32'h0BADF00D; b_wmask = 4'hF; a_wmask = 4'hF;
    for (int i = 0; i < 13; i++) begin
      a_valid = tbl[i].av; b_valid = tbl[i].bv;
      a_we = tbl[i].awe;   b_we = tbl[i].bwe;
      a_addr = tbl[i].aad; b_addr = tbl[i].bad;
      tick(1, tbl[i].ear, tbl[i].ebr);
    end
    idle(3);

    // A write then read back next cycle
    a_valid = 1; a_we = 1; a_addr = 8'h10;
    a_wdata = 32'hDEADBEEF; a_wmask = 4'hF;
    tick(0, 0, 0);
    a_we = 0;
    tick(0, 0, 0);
    idle(1);
    idle(1);
    chk("wr_rd_rvalid", a_rvalid, 1'b1);
    chk("wr_rd_data", a_rdata, 32'hDEADBEEF);

    // Partial write over all-ones
    a_valid = 1; a_we = 1; a_addr = 8'h20;
    a_wdata = 32'hFFFFFFFF; a_wmask = 4'hF;
    tick(0, 0, 0);
    a_wdata = 32'h11223344; a_wmask = 4'b0101;
    tick(0, 0, 0);
    a_we = 0;
    tick(0, 0, 0);
    idle(2);
    chk("partial_data", a_rdata, 32'hFF22FF44);
    idle(1);

    // Reset one cycle after a B read is accepted
    b_valid = 1; b_we = 0; b_addr = 8'h20;
    tick(0, 0, 0);
    b_valid = 0; rst0 = 1;
    tick(0, 0, 0);
    rst0 = 0;
    idle(3);
    chk("rst_no_b_rvalid", b_rdata, 32'h0);
    a_valid = 1; b_valid = 1; a_we = 0; b_we = 0;
    a_addr = 8'h05; b_addr = 8'h06;
    tick(1, 1, 0);
    a_valid = 0;
    tick(0, 0, 0);
    idle(3);

    // Streaming reads 0x00-0x07
    a_valid = 1; a_we = 0;
    for (int i = 0; i < 8; i++) begin
      a_addr = 8'(i);
      tick(0, 0, 0);
    end
    idle(3);

    // Randomized traffic; unserved requests stay stable
    g_a = 0; g_b = 0;
    for (int n = 0; n < 400; n++) begin
      if (!(a_valid && !g_a)) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_we = 1'($urandom_range(0, 1));
        a_addr = 8'($urandom_range(0, 15));
        a_wdata = $urandom;
        a_wmask = 4'($urandom_range(0, 15));
      end
      if (!(b_valid && !g_b)) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_we = 1'($urandom_range(0, 1));
        b_addr = 8'($urandom_range(0, 15));
        b_wdata = $urandom;
        b_wmask = 4'($urandom_range(0, 15));
      end
      tick(0, 0, 0);
    end
    idle(4);
    chk("queues_drained", 32'(qa.size() + qb.size()), 32'h0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
